// File: rtl/riscp_pkg.sv
// Shared definitions for the 128-bit pipelined RISC datapath.
// Holds datapath sizing, instruction field positions, ALU opcode encodings,
// NZC flag indices, and small helpers that slice instruction fields.
package riscp_pkg;

  localparam int WIDTH = 128;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  // Instruction field bit positions: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;

  // ALU opcodes; 4'b1101..4'b1111 are undefined and treated as PASS_S by the ALU
  localparam logic [3:0] OP_PASS_S = 4'b0000;
  localparam logic [3:0] OP_PASS_R = 4'b0001;
  localparam logic [3:0] OP_INC    = 4'b0010;
  localparam logic [3:0] OP_DEC    = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_SHR    = 4'b0110;
  localparam logic [3:0] OP_SHL    = 4'b0111;
  localparam logic [3:0] OP_AND    = 4'b1000;
  localparam logic [3:0] OP_OR     = 4'b1001;
  localparam logic [3:0] OP_XOR    = 4'b1010;
  localparam logic [3:0] OP_NOT    = 4'b1011;
  localparam logic [3:0] OP_NEG    = 4'b1100;

  // Status flag indices within {N,Z,C}
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  function automatic logic [3:0] instr_op(input logic [15:0] instr);
    return instr[OP_LSB +: 4];
  endfunction

  function automatic logic [AW-1:0] instr_rd(input logic [15:0] instr);
    return instr[RD_LSB +: AW];
  endfunction

  function automatic logic [AW-1:0] instr_rs(input logic [15:0] instr);
    return instr[RS_LSB +: AW];
  endfunction

  function automatic logic [AW-1:0] instr_rt(input logic [15:0] instr);
    return instr[RT_LSB +: AW];
  endfunction

endpackage

// File: rtl/regfile_16x128.sv
// 16 x 128-bit register file.
// Ports: clk/rst_n (async active-low reset clears every entry to zero),
//   we_i/waddr_i/wdata_i synchronous write port,
//   raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o asynchronous read ports.
// Reads return the stored value only; write-to-read forwarding is the
// caller's responsibility.
module regfile_16x128
  import riscp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] mem_q [NREGS];

  // Storage array: cleared on reset, written on the write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-read / issue stage feeding the combinational ALU.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_instr instruction handshake ({op, rd, rs, rt})
//   ex_valid/ex_ready          ID/EX bundle handshake
//   ex_r, ex_s, ex_alu_op, ex_rd  registered ID/EX bundle
//   wb_valid, wb_rd, wb_y, wb_n/z/c  ALU writeback
//   flags                      {N,Z,C} status register
//   busy                       per-register scoreboard pending bits
// Operands are read from the register file with bypass from the writeback
// port. A scoreboard holds issue while any of rs/rt/rd has a result in
// flight; a writeback in the same cycle releases that register at once.
module operand_fetch_stage
  import riscp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [WIDTH-1:0] ex_r,
  output logic [WIDTH-1:0] ex_s,
  output logic [3:0]       ex_alu_op,
  output logic [AW-1:0]    ex_rd,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_y,
  input  logic             wb_n,
  input  logic             wb_z,
  input  logic             wb_c,
  output logic [2:0]       flags,
  output logic [NREGS-1:0] busy
);

  logic [3:0]       op_s;
  logic [AW-1:0]    rd_s, rs_s, rt_s;
  logic [WIDTH-1:0] rf_a_s, rf_b_s;
  logic [WIDTH-1:0] r_s, s_s;
  logic [NREGS-1:0] live_s;
  logic             hazard_s;
  logic             accept_s;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [2:0]       flags_q, flags_d;
  logic             ex_valid_q, ex_valid_d;
  logic [WIDTH-1:0] ex_r_q, ex_r_d, ex_s_q, ex_s_d;
  logic [3:0]       ex_op_q, ex_op_d;
  logic [AW-1:0]    ex_rd_q, ex_rd_d;

  assign op_s = instr_op(in_instr);
  assign rd_s = instr_rd(in_instr);
  assign rs_s = instr_rs(in_instr);
  assign rt_s = instr_rt(in_instr);

  regfile_16x128 u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_valid),
    .waddr_i   (wb_rd),
    .wdata_i   (wb_y),
    .raddr_a_i (rs_s),
    .rdata_a_o (rf_a_s),
    .raddr_b_i (rt_s),
    .rdata_b_o (rf_b_s)
  );

  // Hazard detection: a same-cycle writeback releases its register, and
  // rs/rt are always checked regardless of whether the opcode uses them
  always_comb begin
    live_s = busy_q;
    if (wb_valid) begin
      live_s[wb_rd] = 1'b0;
    end else begin
      live_s = busy_q;
    end
    hazard_s = live_s[rs_s] | live_s[rt_s] | live_s[rd_s];
  end

  assign in_ready = !hazard_s && (!ex_valid_q || ex_ready);
  assign accept_s = in_valid && in_ready;

  // Operand select with writeback bypass
  always_comb begin
    r_s = rf_a_s;
    s_s = rf_b_s;
    if (wb_valid && (wb_rd == rs_s)) begin
      r_s = wb_y;
    end else begin
      r_s = rf_a_s;
    end
    if (wb_valid && (wb_rd == rt_s)) begin
      s_s = wb_y;
    end else begin
      s_s = rf_b_s;
    end
  end

  // Next-state for scoreboard and flags: clear on writeback, then set on
  // accept, so a same-register issue keeps the bit pending
  always_comb begin
    busy_d  = busy_q;
    flags_d = flags_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
      flags_d       = {wb_n, wb_z, wb_c};
    end else begin
      flags_d = flags_q;
    end
    if (accept_s) begin
      busy_d[rd_s] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Next-state for the ID/EX bundle; payload holds while not reloaded
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_r_d     = ex_r_q;
    ex_s_d     = ex_s_q;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    if (accept_s) begin
      ex_valid_d = 1'b1;
      ex_r_d     = r_s;
      ex_s_d     = s_s;
      ex_op_d    = op_s;
      ex_rd_d    = rd_s;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      flags_q    <= 3'b000;
      ex_valid_q <= 1'b0;
      ex_r_q     <= '0;
      ex_s_q     <= '0;
      ex_op_q    <= 4'b0000;
      ex_rd_q    <= 4'b0000;
    end else begin
      busy_q     <= busy_d;
      flags_q    <= flags_d;
      ex_valid_q <= ex_valid_d;
      ex_r_q     <= ex_r_d;
      ex_s_q     <= ex_s_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_r      = ex_r_q;
  assign ex_s      = ex_s_q;
  assign ex_alu_op = ex_op_q;
  assign ex_rd     = ex_rd_q;
  assign flags     = flags_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios followed
// by randomized traffic, all compared against a behavioural model.
module tb_operand_fetch_stage;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_instr;
  logic         ex_valid;
  logic         ex_ready;
  logic [127:0] ex_r;
  logic [127:0] ex_s;
  logic [3:0]   ex_alu_op;
  logic [3:0]   ex_rd;
  logic         wb_valid;
  logic [3:0]   wb_rd;
  logic [127:0] wb_y;
  logic         wb_n, wb_z, wb_c;
  logic [2:0]   flags;
  logic [15:0]  busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of architectural state
  logic [127:0] m_reg [16];
  logic [15:0]  m_busy;
  logic [2:0]   m_flags;
  logic         m_exv;
  logic [127:0] m_exr, m_exs;
  logic [3:0]   m_op, m_rd;

  operand_fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_r      (ex_r),
    .ex_s      (ex_s),
    .ex_alu_op (ex_alu_op),
    .ex_rd     (ex_rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_y      (wb_y),
    .wb_n      (wb_n),
    .wb_z      (wb_z),
    .wb_c      (wb_c),
    .flags     (flags),
    .busy      (busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 128'd0;
    m_busy  = 16'd0;
    m_flags = 3'd0;
    m_exv   = 1'b0;
    m_exr   = 128'd0;
    m_exs   = 128'd0;
    m_op    = 4'd0;
    m_rd    = 4'd0;
  endtask

  function automatic bit pend(input logic [3:0] x);
    return m_busy[x] && !(wb_valid && (wb_rd == x));
  endfunction

  task automatic drive(input logic iv, input logic [15:0] ins, input logic er,
                       input logic wv, input logic [3:0] wrd, input logic [127:0] wy,
                       input logic [2:0] nzc);
    in_valid = iv;
    in_instr = ins;
    ex_ready = er;
    wb_valid = wv;
    wb_rd    = wrd;
    wb_y     = wy;
    {wb_n, wb_z, wb_c} = nzc;
  endtask

  // One clock: check in_ready mid-cycle, advance model, check registered outputs
  task automatic cycle();
    logic [3:0] f_rd, f_rs, f_rt, f_op;
    logic       exp_rdy, acc;
    logic [127:0] r, s;
    @(negedge clk);
    f_op = in_instr[15:12];
    f_rd = in_instr[11:8];
    f_rs = in_instr[7:4];
    f_rt = in_instr[3:0];
    exp_rdy = !(pend(f_rs) || pend(f_rt) || pend(f_rd)) && (!m_exv || ex_ready);
    check_val("in_ready", 128'(in_ready), 128'(exp_rdy));
    acc = in_valid && exp_rdy;
    r = (wb_valid && wb_rd == f_rs) ? wb_y : m_reg[f_rs];
    s = (wb_valid && wb_rd == f_rt) ? wb_y : m_reg[f_rt];
    if (wb_valid) begin
      m_reg[wb_rd]  = wb_y;
      m_flags       = {wb_n, wb_z, wb_c};
      m_busy[wb_rd] = 1'b0;
    end
    if (acc) begin
      m_busy[f_rd] = 1'b1;
      m_exv = 1'b1;
      m_exr = r;
      m_exs = s;
      m_op  = f_op;
      m_rd  = f_rd;
    end else if (ex_ready) begin
      m_exv = 1'b0;
    end
    @(posedge clk);
    #1;
    check_val("ex_valid", 128'(ex_valid), 128'(m_exv));
    check_val("ex_r", ex_r, m_exr);
    check_val("ex_s", ex_s, m_exs);
    check_val("ex_alu_op", 128'(ex_alu_op), 128'(m_op));
    check_val("ex_rd", 128'(ex_rd), 128'(m_rd));
    check_val("busy", 128'(busy), 128'(m_busy));
    check_val("flags", 128'(flags), 128'(m_flags));
  endtask

  initial begin
    int q[$];
    int pick;
    logic [127:0] rv;
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 128'd0, 3'b000);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ex_valid", 128'(ex_valid), 128'd0);
    check_val("rst_busy", 128'(busy), 128'd0);
    check_val("rst_flags", 128'(flags), 128'd0);
    check_val("rst_ex_r", ex_r, 128'd0);
    check_val("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;

    // ADD rd=3 rs=1 rt=2
    drive(1'b1, 16'h4312, 1'b1, 1'b0, 4'd0, 128'd0, 3'b000);
    cycle();
    check_val("tp1_op", 128'(ex_alu_op), 128'h4);
    check_val("tp1_busy", 128'(busy), 128'h0008);

    // Writeback r1=5 flags 001, then PASS_R rd=4 rs=1 rt=0
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 4'd1, 128'h5, 3'b001);
    cycle();
    drive(1'b1, 16'h1410, 1'b1, 1'b0, 4'd0, 128'd0, 3'b000);
    cycle();
    check_val("tp2_ex_r", ex_r, 128'h5);
    check_val("tp2_flags", 128'(flags), 128'h1);

    // RAW: ADD rd=5, then SUB rd=6 rs=5 stalls until writeback of r5
    drive(1'b1, 16'h4512, 1'b1, 1'b0, 4'd0, 128'd0, 3'b000);
    cycle();
    drive(1'b1, 16'h5650, 1'b1, 1'b0, 4'd0, 128'd0, 3'b000);
    cycle();
    cycle();
    drive(1'b1, 16'h5650, 1'b1, 1'b1, 4'd5, 128'hA, 3'b110);
    cycle();
    check_val("tp3_ex_r", ex_r, 128'hA);
    check_val("tp3_busy5", 128'(busy[5]), 128'd0);

    // Backpressure for 3 cycles, then one handoff per cycle
    drive(1'b1, 16'h89AB, 1'b0, 1'b0, 4'd0, 128'd0, 3'b000);
    repeat (3) cycle();
    drive(1'b1, 16'h89AB, 1'b1, 1'b0, 4'd0, 128'd0, 3'b000);
    cycle();
    drive(1'b1, 16'h9ABC, 1'b1, 1'b0, 4'd0, 128'd0, 3'b000);
    cycle();

    // WAW with same-cycle writeback to rd=7; opcode 4'hE passes through
    drive(1'b1, 16'hC700, 1'b1, 1'b0, 4'd0, 128'd0, 3'b000);
    cycle();
    drive(1'b1, 16'hE700, 1'b1, 1'b1, 4'd7, 128'h77, 3'b010);
    cycle();
    check_val("tp5_busy7", 128'(busy[7]), 128'd1);

    // Async reset mid-operation, checked before any clock edge
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 128'd0, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_ex_valid", 128'(ex_valid), 128'd0);
    check_val("arst_busy", 128'(busy), 128'd0);
    check_val("arst_flags", 128'(flags), 128'd0);
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      q.delete();
      for (int i = 0; i < 16; i++) if (m_busy[i]) q.push_back(i);
      rv = {$urandom, $urandom, $urandom, $urandom};
      pick = $urandom_range(0, 9);
      if (q.size() > 0 && pick < 5) begin
        drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
              1'b1, 4'(q[$urandom_range(0, q.size() - 1)]), rv, 3'($urandom));
      end else if (pick < 7) begin
        drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
              1'b1, 4'($urandom), rv, 3'($urandom));
      end else begin
        drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0),
              1'b0, 4'($urandom), rv, 3'($urandom));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Register-read/issue stage of the 128-bit pipelined RISC datapath, directly upstream of the combinational ALU. It holds a 16 × 128-bit register file and accepts 16-bit instructions through a valid/ready handshake. It reads R and S operands, with bypass from the writeback port, and drives a registered ID/EX bundle (R, S, Alu_op, destination) into the ALU stage. A per-register scoreboard stalls issue on RAW/WAW hazards against results still in flight, and an NZC status register is updated from ALU writeback.

## Interface
- WIDTH, 128, datapath width
- NREGS, 16, register count (address width 4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept instruction this cycle
- in_instr  in  16  [15:12] alu_op, [11:8] rd, [7:4] rs (→R), [3:0] rt (→S)
- ex_valid  out  1  ID/EX bundle valid
- ex_ready  in  1  ALU stage consumes bundle
- ex_r  out  WIDTH  operand R
- ex_s  out  WIDTH  operand S
- ex_alu_op  out  4  ALU opcode
- ex_rd  out  4  destination register, carried to writeback
- wb_valid  in  1  writeback strobe
- wb_rd  in  4  writeback register
- wb_y  in  WIDTH  ALU result Y
- wb_n, wb_z, wb_c  in  1 each  ALU status flags
- flags  out  3  {N,Z,C} status register
- busy  out  NREGS  scoreboard pending bits

## Operation
- Accept = in_valid && in_ready.
- in_ready = !hazard && (!ex_valid || ex_ready). in_ready is combinational from in_instr, the scoreboard, wb_*, and ex_ready.
- A register x is live-pending when busy[x] && !(wb_valid && wb_rd==x), i.e. a same-cycle writeback clears the hazard.
- hazard = live-pending(rs) || live-pending(rt) || live-pending(rd) (WAW).
- All opcodes check rs and rt, including unary and pass ops; the check is conservative and decoding ignores usage.
- Operand read is asynchronous. If wb_valid && wb_rd==rs, ex_r takes wb_y (bypass); same for rt/ex_s. Otherwise the file value is used.
- Register write: on wb_valid, reg[wb_rd] <= wb_y and flags <= {wb_n,wb_z,wb_c}. Writeback to a non-pending register still writes and does not error.
- Scoreboard per cycle:
  - clear busy[wb_rd] on wb_valid;
  - then set busy[rd] on accept.
  - Set wins when rd==wb_rd in the same cycle.
- ID/EX register:
  - On accept, load {r,s,alu_op,rd} and set ex_valid.
  - Else if ex_ready, clear ex_valid.
  - While ex_valid && !ex_ready, all ex_* hold stable.
- Opcodes ≥ 4'b1101 pass through unchanged; the ALU defaults them to pass S.
- Arithmetic: none in this stage. Widths pass through unmodified.

## Timing
- Reset (async assert, sync-safe release): all registers 0, busy=0, flags=0, ex_valid=0, ex_r=ex_s=0, ex_alu_op=0, ex_rd=0.
  - in_ready=1 after reset once ex_valid=0.
- Latency: an instruction accepted at edge k is presented on ex_* with ex_valid=1 immediately after edge k.
- Throughput: one instruction per cycle when hazard-free and ex_ready=1.
- Dependent instruction: stalls until the cycle the producer's wb_valid arrives, then issues that cycle with bypassed data.
  - Minimum back-to-back dependent spacing equals the downstream result latency.
- Reset mid-operation:
  - in-flight bundles are discarded and the scoreboard is cleared;
  - writebacks arriving after reset are written normally and do not set busy.

## Structure
- Shared package riscp_pkg holds:
  - WIDTH and NREGS constants;
  - instruction field bit positions;
  - ALU opcode localparams 4'b0000–4'b1100 (PASS_S, PASS_R, INC, DEC, ADD, SUB, SHR, SHL, AND, OR, XOR, NOT, NEG);
  - flag index constants N=2, Z=1, C=0.
- One sub-module: regfile_16x128, with two asynchronous read ports, one synchronous write port, and async active-low reset to zero.
- Hazard, bypass, scoreboard and ID/EX register logic stay in operand_fetch_stage.

## Test plan
- Reset, then issue ADD rd=3 rs=1 rt=2 with ex_ready=1 → ex_valid next cycle, ex_alu_op=4'b0100, ex_rd=3, ex_r=ex_s=0, busy=16'h0008.
- wb_valid rd=1 y=128'h5, then PASS_R rd=4 rs=1 rt=0 → ex_r=128'h5; wb_n/z/c=0/0/1 gives flags=3'b001.
- RAW: issue ADD rd=5, then SUB rs=5 → in_ready=0 until wb_valid rd=5 y=128'hA, then SUB issues that cycle with ex_r=128'hA (bypass) and busy[5] ends 0.
- Backpressure: hold ex_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and ex_* stable; ex_ready=1 → one handoff per cycle resumes.
- WAW/same-cycle: busy[7] set, wb_rd=7 arrives with new instr rd=7 → accepted, busy[7] remains 1.
- Async reset asserted with ex_valid=1 and busy≠0 → ex_valid=0, busy=0, flags=0 immediately, without waiting for clk.
